// File: rtl/alu_issue_ctrl.sv
// Requester side of the ALU operand/result interface: issues ops on a valid/ready
// handshake and collects fixed-latency results into an in-order, credit-protected FIFO.
module alu_issue_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int CTRL_WIDTH   = 4,
    parameter int STATUS_WIDTH = 4,
    parameter int SHAMT_WIDTH  = 5,
    parameter int ALU_LATENCY  = 1,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [CTRL_WIDTH-1:0]   req_ctrl,
    input  logic [DATA_WIDTH-1:0]   req_a,
    input  logic [DATA_WIDTH-1:0]   req_b,
    input  logic [SHAMT_WIDTH-1:0]  req_shamt,
    output logic                    alu_en_n,
    output logic [2*DATA_WIDTH-1:0] alu_dataIn,
    output logic [CTRL_WIDTH-1:0]   alu_ctrl,
    output logic [SHAMT_WIDTH-1:0]  alu_shamt,
    input  logic [DATA_WIDTH-1:0]   alu_dataOut,
    input  logic [DATA_WIDTH-1:0]   alu_hi,
    input  logic [DATA_WIDTH-1:0]   alu_lo,
    input  logic [STATUS_WIDTH-1:0] alu_status,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [DATA_WIDTH-1:0]   rsp_hi,
    output logic [DATA_WIDTH-1:0]   rsp_lo,
    output logic [STATUS_WIDTH-1:0] rsp_status
);
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int AW = $clog2(RESP_DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   data;
        logic [DATA_WIDTH-1:0]   hi;
        logic [DATA_WIDTH-1:0]   lo;
        logic [STATUS_WIDTH-1:0] status;
    } rsp_t;

    logic                   accept, pop, wr;
    logic [ALU_LATENCY-1:0] vld_pipe, vld_nxt;
    logic [CW-1:0]          out_cnt, out_nxt, count, count_nxt;
    logic [AW-1:0]          wptr, rptr;
    rsp_t                   mem [RESP_DEPTH];
    rsp_t                   wr_ent, head;

    assign accept = req_valid && req_ready;
    assign pop    = rsp_valid && rsp_ready;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(RESP_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // ---------------- issue ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_en_n   <= 1'b1;
            alu_dataIn <= '0;
            alu_ctrl   <= '0;
            alu_shamt  <= '0;
        end else if (accept) begin
            alu_en_n   <= 1'b0;
            alu_dataIn <= {req_a, req_b};
            alu_ctrl   <= req_ctrl;
            alu_shamt  <= req_shamt;
        end else begin
            alu_en_n   <= 1'b1;
        end
    end

    // ---------------- pending tracker ----------------
    generate
        if (ALU_LATENCY == 1) begin : g_lat1
            assign vld_nxt = accept;
        end else begin : g_latn
            assign vld_nxt = {vld_pipe[ALU_LATENCY-2:0], accept};
        end
    endgenerate

    assign wr = vld_pipe[ALU_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= vld_nxt;
    end

    // ---------------- response FIFO ----------------
    assign wr_ent    = {alu_dataOut, alu_hi, alu_lo, alu_status};
    assign count_nxt = count + CW'(wr) - CW'(pop);

    // No full check on write: the credit counter never lets more ops out than slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RESP_DEPTH; i++) mem[i] <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rsp_valid <= 1'b0;
        end else begin
            if (wr) begin
                mem[wptr] <= wr_ent;
                wptr      <= ptr_inc(wptr);
            end
            if (pop) rptr <= ptr_inc(rptr);
            count     <= count_nxt;
            rsp_valid <= (count_nxt != '0);
        end
    end

    assign head       = mem[rptr];
    assign rsp_data   = head.data;
    assign rsp_hi     = head.hi;
    assign rsp_lo     = head.lo;
    assign rsp_status = head.status;

    // ---------------- credit ----------------
    assign out_nxt = out_cnt + CW'(accept) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt   <= '0;
            req_ready <= 1'b0;
        end else begin
            out_cnt   <= out_nxt;
            req_ready <= (out_nxt < CW'(RESP_DEPTH));
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator/requester side of the ALU operand/result interface.
- Accepts operation requests over a valid/ready handshake and drives the ALU's packed operand bus, ctrl, shamt and en_n.
- Captures dataOut/hi/lo/status a fixed number of cycles later into an in-order response FIFO with its own valid/ready handshake.
- Credit tracking guarantees no ALU result is ever dropped. The ALU itself cannot stall.

Parameters:
- DATA_WIDTH, 32, operand/result width
- CTRL_WIDTH, 4, ALU opcode width
- STATUS_WIDTH, 4, status flag width
- SHAMT_WIDTH, 5, shift amount width
- ALU_LATENCY, 1, clock edges from the issue edge to the result sample edge; legal range 1..8
- RESP_DEPTH, 4, response FIFO entries and total outstanding-operation credit; must be >= 2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready at clk edge
- req_ctrl  in  CTRL_WIDTH  ALU opcode
- req_a  in  DATA_WIDTH  operand A (upper half of packed bus)
- req_b  in  DATA_WIDTH  operand B (lower half)
- req_shamt  in  SHAMT_WIDTH  shift amount
- alu_en_n  out  1  active-low ALU enable
- alu_dataIn  out  2*DATA_WIDTH  {req_a, req_b}
- alu_ctrl  out  CTRL_WIDTH  opcode to ALU
- alu_shamt  out  SHAMT_WIDTH  shift amount to ALU
- alu_dataOut  in  DATA_WIDTH  ALU result
- alu_hi  in  DATA_WIDTH  ALU product high word
- alu_lo  in  DATA_WIDTH  ALU product low word
- alu_status  in  STATUS_WIDTH  {overflow, carry, sign, zero}
- rsp_valid  out  1  response valid (FIFO non-empty)
- rsp_ready  in  1  response popped when rsp_valid && rsp_ready at clk edge
- rsp_data  out  DATA_WIDTH  captured dataOut
- rsp_hi  out  DATA_WIDTH  captured hi
- rsp_lo  out  DATA_WIDTH  captured lo
- rsp_status  out  STATUS_WIDTH  captured status

Behaviour:

Reset (rst_n low, asynchronous):
- alu_en_n=1; alu_dataIn, alu_ctrl, alu_shamt = 0.
- req_ready=0; rsp_valid=0; rsp_* data = 0.
- Credit counter, FIFO pointers/count and pending shift register cleared.
- All in-flight and buffered results are discarded.
- req_ready rises at the first clk edge after rst_n deasserts.

Issue (acceptance edge E0):
- alu_dataIn<={req_a,req_b}, alu_ctrl<=req_ctrl, alu_shamt<=req_shamt, alu_en_n<=0.
- Without acceptance: alu_en_n<=1 and operand/ctrl/shamt registers hold their values.
- alu_en_n is therefore low for exactly one cycle per accepted operation.

Pending tracker:
- ALU_LATENCY-bit shift register; bit 0 is set at E0 and the register shifts every edge.
- At edge E0+ALU_LATENCY, alu_dataOut, alu_hi, alu_lo and alu_status are written into the FIFO tail as one entry.
- Writes happen unconditionally; credit guarantees space.

Response FIFO:
- RESP_DEPTH entries, show-ahead, in-order. rsp_* reflects the head entry.
- rsp_valid = count != 0, registered.
- Simultaneous write and pop: count unchanged; both take effect.
- A write into an empty FIFO becomes visible the cycle after the write edge. There is no bypass.
- rsp_* data is stable while rsp_valid && !rsp_ready.

Credit:
- outstanding = in-flight + FIFO count, range 0..RESP_DEPTH.
- +1 on accept, -1 on pop, unchanged when both occur in the same cycle.
- req_ready is registered: req_ready <= (outstanding_next < RESP_DEPTH). No combinational path from rsp_ready or req_valid to req_ready.
- After a pop at edge Ep from the full state, req_ready is high in the cycle following Ep.
- Full throughput of one op per cycle with rsp_ready=1 requires RESP_DEPTH >= ALU_LATENCY+2.

Misc:
- All opcodes are passed through unmodified, including reserved ones; unknown ops still occupy one credit and return one response.
- Responses are never reordered, duplicated or dropped outside of reset.

Test Plan:
1. Reset: hold rst_n low with req_valid=1 -> alu_en_n=1, rsp_valid=0, req_ready=0, no accept. Release rst_n -> req_ready=1 after first edge.
2. Single add: a=5, b=7, ctrl=4'h4, ALU model latency 1 -> alu_dataIn=64'h00000005_00000007 and alu_en_n low one cycle. Then rsp_valid=1, rsp_data=12, zero flag 0, after the 2nd edge following acceptance. Pop -> rsp_valid=0.
3. Mult: a=32'h00010000, b=32'h00010000, ctrl=4'h6 -> rsp_hi=1, rsp_lo=0, rsp_data=0, rsp_status[0]=1.
4. Stream of 8 ops (ctrl=4'h4, a=i, b=1) with rsp_ready=1 -> req_ready never drops, one response per cycle, rsp_data=1..8 in order.
5. Backpressure, rsp_ready=0, continuous req_valid -> exactly 4 accepted, req_ready=0, rsp_valid held with stable head data. Single pop -> req_ready=1 the next cycle, exactly one more accept.
6. Assert rst_n low with 3 ops in flight/buffered -> rsp_valid=0 immediately. After release, no stale response ever appears; a new op returns the correct result.
